// File: rtl/wb_scoreboard_pkg.sv
// Shared constants and encodings for the write-in-flight scoreboard.
package wb_scoreboard_pkg;

    localparam int unsigned DEF_NREGS        = 32;
    localparam int unsigned DEF_ADDR_W       = 5;
    localparam int unsigned DEF_NRD          = 2;
    localparam int unsigned DEF_MAX_INFLIGHT = 4;
    localparam int unsigned DEF_CNT_W        = 3;
    localparam int unsigned DEF_TOT_W        = 3;

    // Width of one register-address bus.
    localparam int unsigned REG_ADDR_BUS_W   = DEF_ADDR_W;

    // Reserved encodings for per-cause error reporting.
    typedef enum logic [1:0] {
        ERR_NONE         = 2'd0,
        ERR_ISSUE_FULL   = 2'd1,
        ERR_RETIRE_EMPTY = 2'd2
    } err_cause_e;

endpackage

// File: rtl/wb_scoreboard_cnt_cell.sv
// One per-register outstanding-write counter with clear, increment and decrement.
module sb_cnt_cell #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             nonzero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(inc) - CNT_W'(dec);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count   = cnt_q;
    assign nonzero = |cnt_q;

endmodule

// File: rtl/wb_scoreboard.sv
// Per-register write-in-flight scoreboard: hazard query ports, global in-flight
// limit, sticky protocol error and flush.
module wb_scoreboard
    import wb_scoreboard_pkg::*;
#(
    parameter int unsigned NREGS        = DEF_NREGS,
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned NRD          = DEF_NRD,
    parameter int unsigned MAX_INFLIGHT = DEF_MAX_INFLIGHT,
    parameter int unsigned CNT_W        = DEF_CNT_W,
    parameter int unsigned TOT_W        = DEF_TOT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic                  issue_regwr,
    input  logic [ADDR_W-1:0]     issue_rd,
    output logic                  issue_ready,
    input  logic                  retire_valid,
    input  logic [ADDR_W-1:0]     retire_rd,
    input  logic                  flush,
    input  logic [NRD*ADDR_W-1:0] rs_addr,
    output logic [NRD-1:0]        raw,
    output logic                  full,
    output logic                  empty,
    output logic [TOT_W-1:0]      inflight,
    output logic                  err
);

    localparam int unsigned NADDR = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_SAT = '1;
    localparam logic [TOT_W-1:0] TOT_MAX = TOT_W'(MAX_INFLIGHT);

    logic [CNT_W-1:0] cnt_w [NADDR];
    logic [NADDR-1:0] nz_w;

    logic [TOT_W-1:0] total_q, total_d;
    logic             err_q, err_d;
    logic             wr_req, alloc, issue_err;
    logic             ret_req, ret, ret_err;

    // Register 0 and addresses beyond NREGS read as permanently idle.
    for (genvar r = 0; r < NADDR; r++) begin : g_reg
        if (r == 0 || r >= NREGS) begin : g_none
            assign cnt_w[r] = '0;
            assign nz_w[r]  = 1'b0;
        end else begin : g_cell
            sb_cnt_cell #(
                .CNT_W(CNT_W)
            ) u_cell (
                .clk    (clk),
                .rst    (rst),
                .inc    (alloc && (issue_rd == ADDR_W'(r))),
                .dec    (ret && (retire_rd == ADDR_W'(r))),
                .clr    (flush),
                .count  (cnt_w[r]),
                .nonzero(nz_w[r])
            );
        end
    end

    // Admission and retire gating, all from pre-update state.
    always_comb begin
        wr_req      = issue_valid && issue_regwr && (issue_rd != '0);
        issue_ready = !(issue_regwr && (issue_rd != '0))
                      || ((total_q < TOT_MAX) && (cnt_w[issue_rd] != CNT_SAT));
        alloc       = wr_req && issue_ready;
        issue_err   = wr_req && !issue_ready;
        ret_req     = retire_valid && (retire_rd != '0);
        ret         = ret_req && nz_w[retire_rd];
        ret_err     = ret_req && !nz_w[retire_rd];
        total_d     = total_q;
        err_d       = err_q;
        if (flush) begin
            total_d = '0;
            err_d   = 1'b0;
        end else begin
            total_d = total_q + TOT_W'(alloc) - TOT_W'(ret);
            err_d   = err_q | issue_err | ret_err;
        end
    end

    always_comb begin
        raw = '0;
        for (int i = 0; i < NRD; i++) begin
            raw[i] = nz_w[rs_addr[i*ADDR_W +: ADDR_W]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            total_q <= '0;
            err_q   <= 1'b0;
        end else begin
            total_q <= total_d;
            err_q   <= err_d;
        end
    end

    assign full     = (total_q == TOT_MAX);
    assign empty    = (total_q == '0);
    assign inflight = total_q;
    assign err      = err_q;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Self-checking bench for wb_scoreboard: directed vector table plus a randomised
// phase checked against a reference model through an expectation queue.
module tb_wb_scoreboard;
    import wb_scoreboard_pkg::*;

    localparam int unsigned AW   = DEF_ADDR_W;
    localparam int unsigned NRD  = DEF_NRD;
    localparam int unsigned TW   = DEF_TOT_W;
    localparam int unsigned MAXF = DEF_MAX_INFLIGHT;
    localparam int unsigned SAT  = (1 << DEF_CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              issue_valid, issue_regwr, issue_ready;
    logic [AW-1:0]     issue_rd;
    logic              retire_valid;
    logic [AW-1:0]     retire_rd;
    logic              flush;
    logic [NRD*AW-1:0] rs_addr;
    logic [NRD-1:0]    raw;
    logic              full, empty, err;
    logic [TW-1:0]     inflight;

    wb_scoreboard dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_regwr (issue_regwr),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .retire_valid(retire_valid),
        .retire_rd   (retire_rd),
        .flush       (flush),
        .rs_addr     (rs_addr),
        .raw         (raw),
        .full        (full),
        .empty       (empty),
        .inflight    (inflight),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          iv, rw;
        logic [AW-1:0] ird;
        logic          rv;
        logic [AW-1:0] rrd;
        logic          fl;
        logic [AW-1:0] rs0, rs1;
        logic [1:0]    e_raw;
        logic          e_rdy;
        logic [TW-1:0] e_inf;
        logic          e_err;
    } vec_t;

    typedef struct {
        logic [TW-1:0] inf;
        logic          err;
        logic          full;
        logic          empty;
    } post_t;

    post_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    bit    inv_on   = 1'b0;

    // Reference model state for the random phase.
    int    mcnt[32];
    int    mtot;
    bit    merr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic rw, input logic [AW-1:0] ird,
                         input logic rv, input logic [AW-1:0] rrd, input logic fl,
                         input logic [AW-1:0] rs0, input logic [AW-1:0] rs1);
        issue_valid  = iv;
        issue_regwr  = rw;
        issue_rd     = ird;
        retire_valid = rv;
        retire_rd    = rrd;
        flush        = fl;
        rs_addr      = {rs1, rs0};
    endtask

    function automatic post_t mk_post(input int tot, input bit e);
        post_t p;
        p.inf   = TW'(tot);
        p.err   = e;
        p.full  = (tot == int'(MAXF));
        p.empty = (tot == 0);
        return p;
    endfunction

    // Clock the edge, then pop the expected post-edge state and compare.
    task automatic edge_and_check(input string tag);
        post_t p;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_queue: got empty expectation queue required 1 entry", tag);
        end else begin
            p = exp_q.pop_front();
            chk({tag, "_inflight"}, 32'(inflight), 32'(p.inf));
            chk({tag, "_err"},      32'(err),      32'(p.err));
            chk({tag, "_full"},     32'(full),     32'(p.full));
            chk({tag, "_empty"},    32'(empty),    32'(p.empty));
        end
    endtask

    // Sum of per-register counters must always equal the reported total.
    always @(negedge clk) begin
        if (inv_on) begin
            int sum;
            sum = 0;
            for (int r = 0; r < 32; r++) sum += int'(dut.cnt_w[r]);
            checks++;
            if (sum != int'(inflight)) begin
                failures++;
                $display("FAIL invariant_sum: got %0d expected %0d at %0t", sum, inflight, $time);
            end
        end
    end

    vec_t tbl[24];

    initial begin
        // iv rw ird rv rrd fl rs0 rs1 | raw rdy inf err
        tbl[0]  = '{0,0,0, 0,0, 0, 0,0, 2'b00,1,0,0};  // idle
        tbl[1]  = '{1,1,5, 0,0, 0, 5,6, 2'b00,1,1,0};  // issue x5
        tbl[2]  = '{0,0,0, 0,0, 0, 5,6, 2'b01,1,1,0};
        tbl[3]  = '{0,0,0, 1,5, 0, 5,6, 2'b01,1,0,0};  // retire x5, raw holds
        tbl[4]  = '{0,0,0, 0,0, 0, 5,6, 2'b00,1,0,0};
        tbl[5]  = '{1,1,7, 0,0, 0, 7,0, 2'b00,1,1,0};  // double write x7
        tbl[6]  = '{1,1,7, 0,0, 0, 7,0, 2'b01,1,2,0};
        tbl[7]  = '{0,0,0, 1,7, 0, 7,0, 2'b01,1,1,0};
        tbl[8]  = '{0,0,0, 0,0, 0, 0,7, 2'b10,1,1,0};
        tbl[9]  = '{0,0,0, 1,7, 0, 7,0, 2'b01,1,0,0};
        tbl[10] = '{0,0,0, 0,0, 0, 7,7, 2'b00,1,0,0};
        tbl[11] = '{1,1,0, 0,0, 0, 0,0, 2'b00,1,0,0};  // x0 issue ignored
        tbl[12] = '{0,0,0, 1,0, 0, 0,0, 2'b00,1,0,0};  // x0 retire no err
        tbl[13] = '{1,1,1, 0,0, 0, 1,2, 2'b00,1,1,0};  // fill to capacity
        tbl[14] = '{1,1,2, 0,0, 0, 1,2, 2'b01,1,2,0};
        tbl[15] = '{1,1,3, 0,0, 0, 1,2, 2'b11,1,3,0};
        tbl[16] = '{1,1,4, 0,0, 0, 3,4, 2'b01,1,4,0};
        tbl[17] = '{0,1,8, 0,0, 0, 4,8, 2'b01,0,4,0};  // full: not ready
        tbl[18] = '{0,0,8, 0,0, 0, 4,8, 2'b01,1,4,0};  // regwr=0: ready
        tbl[19] = '{1,1,8, 1,1, 0, 1,0, 2'b01,0,3,1};  // issue blocked, retire ok
        tbl[20] = '{1,1,9, 1,2, 1, 2,3, 2'b11,1,0,0};  // flush wins
        tbl[21] = '{0,0,0, 0,0, 0, 2,3, 2'b00,1,0,0};
        tbl[22] = '{0,0,0, 1,2, 0, 2,0, 2'b00,1,0,1};  // retire of flushed reg
        tbl[23] = '{0,0,0, 0,0, 1, 0,0, 2'b00,1,0,0};  // flush clears err

        // Reset
        drive(0, 0, 0, 0, 0, 0, 5, 6);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_inflight", 32'(inflight), 0);
        chk("rst_empty",    32'(empty),    1);
        chk("rst_full",     32'(full),     0);
        chk("rst_raw",      32'(raw),      0);
        chk("rst_err",      32'(err),      0);
        chk("rst_ready",    32'(issue_ready), 1);
        inv_on = 1'b1;

        // Directed vector table
        for (int v = 0; v < 24; v++) begin
            drive(tbl[v].iv, tbl[v].rw, tbl[v].ird, tbl[v].rv, tbl[v].rrd,
                  tbl[v].fl, tbl[v].rs0, tbl[v].rs1);
            #1;
            chk($sformatf("v%0d_raw", v),   32'(raw),         32'(tbl[v].e_raw));
            chk($sformatf("v%0d_ready", v), 32'(issue_ready), 32'(tbl[v].e_rdy));
            exp_q.push_back(mk_post(int'(tbl[v].e_inf), tbl[v].e_err));
            edge_and_check($sformatf("v%0d", v));
        end

        // Random phase against the reference model, starting from reset.
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        foreach (mcnt[r]) mcnt[r] = 0;
        mtot = 0;
        merr = 1'b0;
        for (int c = 0; c < 400; c++) begin
            logic          iv, rw, rv, fl, wr, rdy, al, rt;
            logic [AW-1:0] ird, rrd, rs0, rs1;
            logic [1:0]    eraw;
            iv  = ($urandom_range(3) != 0);
            rw  = ($urandom_range(3) != 0);
            ird = AW'($urandom_range(7));
            rv  = ($urandom_range(2) == 0);
            rrd = AW'($urandom_range(7));
            fl  = ($urandom_range(29) == 0);
            rs0 = AW'($urandom_range(7));
            rs1 = AW'($urandom_range(7));
            drive(iv, rw, ird, rv, rrd, fl, rs0, rs1);

            rdy     = !(rw && ird != 0) || (mtot < int'(MAXF) && mcnt[ird] != int'(SAT));
            eraw[0] = (rs0 != 0) && (mcnt[rs0] != 0);
            eraw[1] = (rs1 != 0) && (mcnt[rs1] != 0);
            wr      = iv && rw && (ird != 0);
            al      = wr && rdy;
            rt      = rv && (rrd != 0) && (mcnt[rrd] != 0);
            #1;
            chk("rnd_raw",   32'(raw),         32'(eraw));
            chk("rnd_ready", 32'(issue_ready), 32'(rdy));

            if (fl) begin
                foreach (mcnt[r]) mcnt[r] = 0;
                mtot = 0;
                merr = 1'b0;
            end else begin
                if (wr && !rdy) merr = 1'b1;
                if (rv && rrd != 0 && mcnt[rrd] == 0) merr = 1'b1;
                if (al) mcnt[ird]++;
                if (rt) mcnt[rrd]--;
                mtot = mtot + int'(al) - int'(rt);
            end
            exp_q.push_back(mk_post(mtot, merr));
            edge_and_check("rnd");
        end

        inv_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_scoreboard.md
Name: wb_scoreboard

Overview:
Parametrised write-in-flight scoreboard. It succeeds the fixed single-entry RAW tracker that sits between decode and writeback in the 5-stage RV64 pipeline. It counts outstanding register writes per architectural register, so several in-flight writes to the same rd are tracked. It supports NRD source-read ports, a global in-flight limit and a pipeline flush. Decode queries hazards and allocates; writeback retires.

Parameters:
NREGS, 32, number of architectural registers; register 0 is never tracked
ADDR_W, 5, register address width; NREGS <= 2**ADDR_W
NRD, 2, number of source-operand hazard query ports
MAX_INFLIGHT, 4, maximum total outstanding writes across all registers
CNT_W, 3, per-register counter width; a counter saturates at 2**CNT_W-1
TOT_W, 3, width of the total counter; must hold MAX_INFLIGHT

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
issue_valid  in  1  decode issues an instruction this cycle
issue_regwr  in  1  issued instruction writes rd
issue_rd  in  ADDR_W  destination register of the issued instruction
issue_ready  out  1  allocation can be accepted this cycle
retire_valid  in  1  writeback commits a register write this cycle
retire_rd  in  ADDR_W  register being committed
flush  in  1  discard all outstanding entries
rs_addr  in  NRD*ADDR_W  packed source addresses; port i occupies bits [i*ADDR_W +: ADDR_W]
raw  out  NRD  bit i set = rs_addr[i] has a pending write
full  out  1  total outstanding == MAX_INFLIGHT
empty  out  1  total outstanding == 0
inflight  out  TOT_W  current total outstanding count
err  out  1  sticky protocol error

Behaviour:
- Clock and reset: single clock, clk; reset synchronous and active-high on rst; all state updates on the rising edge.
- Reset: all per-register counters = 0, total = 0, err = 0. Outputs after reset: empty=1, full=0, inflight=0, raw=0, issue_ready=1.
- State: cnt[r] (CNT_W bits) for r = 1..NREGS-1, plus total (TOT_W bits). cnt[0] is hard-wired to 0.
- raw[i] = (rs_addr[i] != 0) && (cnt[rs_addr[i]] != 0). Purely combinational from registered state. A retire in the same cycle does NOT clear raw; raw clears the following cycle.
- issue_ready = (total < MAX_INFLIGHT) && (cnt[issue_rd] != saturate value). issue_ready is 1 whenever issue_rd == 0 or issue_regwr == 0, independent of rd.
- Allocation condition: alloc = issue_valid && issue_regwr && issue_rd != 0 && issue_ready.
- Issue when not ready: if issue_valid && issue_regwr && issue_rd != 0 && !issue_ready, state is unchanged and err is set. Decode must stall on !issue_ready.
- Retire condition: ret = retire_valid && retire_rd != 0 && cnt[retire_rd] != 0.
- Retire with nothing outstanding: if retire_valid && retire_rd != 0 && cnt[retire_rd] == 0, ret is not performed and err is set.
- Update (one-cycle latency):
  - cnt[rd] += alloc; cnt[retire_rd] -= ret.
  - Same register in both: net change 0.
  - total += alloc - ret.
- A same-cycle retire does not free capacity for a same-cycle issue; issue_ready uses pre-update state.
- Flush: next state = all counters 0, total 0, err 0.
  - Flush overrides alloc and retire in the same cycle.
  - Writeback of flushed instructions must already have been suppressed by the pipeline.
- err is sticky; cleared only by rst or flush.
- full, empty and inflight are decoded directly from total.
- Invariant: total == sum of cnt[]. A bench assertion checks it every cycle.
- Counter wrap never occurs: saturation is blocked by issue_ready and underflow by the ret gating.

Decomposition:
- Shared package: NREGS, ADDR_W, RegAddrBus width macro (already in defines), and error-cause encodings should per-cause error reporting be added.
- One natural sub-module: sb_cnt_cell, one per register. Inputs: inc, dec, clr. Outputs: count and nonzero. Generated NREGS-1 times.
- The top level holds the total counter, the read-port muxes and the error logic.

Test Plan:
- Reset then idle: rst high 1 cycle -> empty=1, full=0, inflight=0, raw=00, err=0.
- Issue rd=5, next cycle rs_addr={5,6} -> raw=01. Retire rd=5 -> raw still 01 that cycle, raw=00 and empty=1 the next cycle.
- Double write: issue rd=7 twice, retire rd=7 once -> raw on port reading x7 stays 1 and inflight=1; second retire -> raw=0, inflight=0.
- Capacity: issue rd=1,2,3,4 -> full=1, issue_ready=0. Issue rd=8 with same-cycle retire rd=1 -> no allocation, err=1, inflight=3 next cycle.
- x0 handling: issue rd=0 and query rs=0 -> inflight unchanged, raw=0. Retire rd=0 -> no err.
- Flush: with 3 outstanding plus simultaneous issue rd=9 and retire rd=2 -> next cycle inflight=0, err=0, all raw=0. Retire rd=2 afterwards -> err=1.
